// File: rtl/game_pkg.sv
// game_pkg: shared playfield constants, colours and sprite direction encoding
package game_pkg;
    localparam int H_VIS = 640;
    localparam int V_VIS = 480;
    localparam logic [7:0] C_BLACK = 8'h00;
    localparam logic [7:0] C_ENEMY = 8'hE0;
    typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} dir_t;
endpackage

// File: rtl/step_timer.sv
// step_timer: free-running motion timer that fires one tick once the count reaches period
module step_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] period,
    output logic        tick
);
    logic [23:0] cnt;
    assign tick = en && cnt >= period;
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 24'd1;
endmodule

// File: rtl/enemy_wave_1.sv
// enemy_wave_1: one marching row of enemies with bounce, drop, hit/respawn and pixel rendering
module enemy_wave_1
    import game_pkg::*;
#(
    parameter int         N_ENEMY       = 5,
    parameter int         E_W           = 32,
    parameter int         E_H           = 24,
    parameter int         E_GAP         = 16,
    parameter int         START_X       = 64,
    parameter int         START_Y       = 32,
    parameter int         DROP          = 8,
    parameter int         RESPAWN_STEPS = 64,
    parameter logic [7:0] E_COLOR       = C_ENEMY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dclk,
    input  logic        pause,
    input  logic        game_start_on,
    input  logic        game_over_on,
    input  logic        p_on,
    input  logic        hit_w_enemy,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [23:0] wave_speed,
    output logic        is_active,
    output logic        e_w_on,
    output logic [7:0]  rgb
);
    localparam int WW   = N_ENEMY * E_W + (N_ENEMY - 1) * E_GAP;
    localparam int SLOT = E_W + E_GAP;
    localparam int RW   = $clog2(RESPAWN_STEPS);
    logic [9:0]    wx, wy;
    dir_t          dir;
    logic [RW-1:0] resp;
    logic          run, tick, unused;
    logic [10:0]   dx;
    assign unused = dclk;
    assign run    = !pause && !game_start_on && !game_over_on;
    step_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (run),
        .period (wave_speed),
        .tick   (tick)
    );
    always_ff @(posedge clk)
        if (rst || game_start_on) begin
            wx        <= 10'(START_X);
            wy        <= 10'(START_Y);
            dir       <= RIGHT;
            resp      <= '0;
            is_active <= 1'b1;
        end else if (run && hit_w_enemy && is_active) begin
            is_active <= 1'b0;
            resp      <= '0;
        end else if (tick) begin
            if (!is_active) begin
                if (resp == RW'(RESPAWN_STEPS - 1)) begin
                    is_active <= 1'b1;
                    resp      <= '0;
                    wx        <= 10'(START_X);
                    wy        <= 10'(START_Y);
                    dir       <= RIGHT;
                end else resp <= resp + 1'b1;
            end else if ({1'b0, wy} + 11'(E_H) >= 11'(V_VIS)) begin
                wx  <= 10'(START_X);
                wy  <= 10'(START_Y);
                dir <= RIGHT;
            end else if (dir == RIGHT) begin
                if ({1'b0, wx} + 11'(WW) >= 11'(H_VIS)) begin
                    dir <= LEFT;
                    wy  <= wy + 10'(DROP);
                end else wx <= wx + 10'd1;
            end else if (wx == '0) begin
                dir <= RIGHT;
                wy  <= wy + 10'(DROP);
            end else wx <= wx - 10'd1;
        end
    // dx is only meaningful when x >= wx, which the x >= wx term guarantees
    assign dx     = {1'b0, x} - {1'b0, wx};
    assign e_w_on = is_active && !game_over_on && x < 10'(H_VIS) && y < 10'(V_VIS)
                    && y >= wy && {1'b0, y} < {1'b0, wy} + 11'(E_H)
                    && x >= wx && dx < 11'(WW) && dx % 11'(SLOT) < 11'(E_W);
    assign rgb    = e_w_on && !p_on ? E_COLOR : C_BLACK;
endmodule

// File: tb/tb_enemy_wave_1.sv
// tb_enemy_wave_1: table vectors, directed corner sequences and random run against a rule-level model
module tb_enemy_wave_1;
    logic        clk = 1'b0, dclk = 1'b0;
    logic        rst, pause, game_start_on, game_over_on, p_on, hit_w_enemy;
    logic [9:0]  x, y;
    logic [23:0] wave_speed;
    logic        is_active, e_w_on;
    logic [7:0]  rgb;
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) dclk <= ~dclk;

    enemy_wave_1 dut (
        .clk(clk), .rst(rst), .dclk(dclk), .pause(pause), .game_start_on(game_start_on),
        .game_over_on(game_over_on), .p_on(p_on), .hit_w_enemy(hit_w_enemy), .x(x), .y(y),
        .wave_speed(wave_speed), .is_active(is_active), .e_w_on(e_w_on), .rgb(rgb)
    );

    typedef struct packed {int wx; int wy; int right; int active; int resp; int cnt;} mst_t;
    mst_t m = '0;

    function automatic mst_t at_start(mst_t s);
        mst_t n = s;
        n.wx = 64; n.wy = 32; n.right = 1;
        return n;
    endfunction

    function automatic mst_t nxt(mst_t s);
        mst_t n = s;
        bit tk;
        if (rst || game_start_on) begin
            n = at_start(s);
            n.active = 1; n.resp = 0;
            if (rst) n.cnt = 0;
            return n;
        end
        if (pause || game_over_on) return n;
        tk = s.cnt >= int'(wave_speed);
        n.cnt = tk ? 0 : s.cnt + 1;
        if (hit_w_enemy && s.active != 0) begin
            n.active = 0; n.resp = 0;
            return n;
        end
        if (!tk) return n;
        if (s.active == 0) begin
            n.resp = s.resp + 1;
            if (n.resp == 64) begin
                n = at_start(n);
                n.active = 1; n.resp = 0;
            end
        end else if (s.wy + 24 >= 480) n = at_start(n);
        else if (s.right != 0) begin
            if (s.wx + 224 >= 640) begin n.right = 0; n.wy = s.wy + 8; end
            else n.wx = s.wx + 1;
        end else if (s.wx == 0) begin n.right = 1; n.wy = s.wy + 8; end
        else n.wx = s.wx - 1;
        return n;
    endfunction

    always @(posedge clk) m <= nxt(m);

    function automatic bit exp_on(int px, int py);
        if (m.active == 0 || game_over_on) return 0;
        if (px >= 640 || py >= 480 || py < m.wy || py >= m.wy + 24) return 0;
        for (int i = 0; i < 5; i++)
            if (px >= m.wx + 48 * i && px < m.wx + 48 * i + 32) return 1;
        return 0;
    endfunction

    task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic pix(string nm, int px, int py, bit pon, bit eo, logic [7:0] er);
        x = 10'(px); y = 10'(py); p_on = pon;
        #2;
        cmp({nm, "/on"}, 32'(e_w_on), 32'(eo));
        cmp({nm, "/rgb"}, 32'(rgb), 32'(er));
    endtask

    task automatic pixm(string nm, int px, int py, bit pon);
        bit eo;
        x = 10'(px); y = 10'(py); p_on = pon;
        #2;
        eo = exp_on(int'(x), int'(y));
        cmp({nm, "/on"}, 32'(e_w_on), 32'(eo));
        cmp({nm, "/rgb"}, 32'(rgb), (eo && !pon) ? 32'hE0 : 32'h0);
        cmp({nm, "/act"}, 32'(is_active), 32'(m.active != 0));
    endtask

    task automatic edges(int n);
        pause = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        pause = 1'b1;
    endtask

    task automatic run_to_wx(string nm, int tgt, int rgt, int budget);
        int g = 0;
        pause = 1'b0;
        while (!(m.wx == tgt && m.right == rgt) && g < budget) begin
            @(posedge clk);
            #1;
            g++;
        end
        pause = 1'b1;
        cmp({nm, "/reached"}, 32'(g < budget), 32'd1);
    endtask

    typedef struct packed {logic [9:0] px; logic [9:0] py; logic pon; logic eo; logic [7:0] er;} vec_t;
    vec_t tbl[12];

    initial begin
        int g;
        int sx;
        rst = 1'b1; pause = 1'b1; game_start_on = 1'b0; game_over_on = 1'b0; p_on = 1'b0;
        hit_w_enemy = 1'b0; x = '0; y = '0; wave_speed = 24'd3;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp("reset/active", 32'(is_active), 32'd1);
        tbl[0]  = '{10'd64,  10'd32, 1'b0, 1'b1, 8'hE0};
        tbl[1]  = '{10'd95,  10'd32, 1'b0, 1'b1, 8'hE0};
        tbl[2]  = '{10'd96,  10'd32, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{10'd111, 10'd32, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{10'd112, 10'd32, 1'b0, 1'b1, 8'hE0};
        tbl[5]  = '{10'd64,  10'd32, 1'b1, 1'b1, 8'h00};
        tbl[6]  = '{10'd63,  10'd32, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{10'd64,  10'd31, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{10'd64,  10'd55, 1'b0, 1'b1, 8'hE0};
        tbl[9]  = '{10'd64,  10'd56, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{10'd287, 10'd32, 1'b0, 1'b1, 8'hE0};
        tbl[11] = '{10'd288, 10'd32, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 12; i++)
            pix($sformatf("tbl%0d", i), int'(tbl[i].px), int'(tbl[i].py), tbl[i].pon, tbl[i].eo, tbl[i].er);
        // wave_speed=3: one pixel every 4 clocks
        edges(8);
        pix("step8_in", 66, 32, 0, 1, 8'hE0);
        pix("step8_out", 65, 32, 0, 0, 8'h00);
        wave_speed = 24'd0;
        run_to_wx("to416", 416, 1, 2000);
        pix("r416_in", 416, 32, 0, 1, 8'hE0);
        pix("r416_out", 415, 32, 0, 0, 8'h00);
        pix("r416_last", 639, 32, 0, 1, 8'hE0);
        edges(1);
        pix("bounceR_in", 416, 40, 0, 1, 8'hE0);
        pix("bounceR_above", 416, 39, 0, 0, 8'h00);
        pix("bounceR_bot", 416, 63, 0, 1, 8'hE0);
        pix("bounceR_below", 416, 64, 0, 0, 8'h00);
        edges(1);
        pix("left_in", 415, 40, 0, 1, 8'hE0);
        pix("left_out", 447, 40, 0, 0, 8'h00);
        run_to_wx("to0", 0, 0, 2000);
        edges(1);
        pix("bounceL_in", 0, 48, 0, 1, 8'hE0);
        pix("bounceL_above", 0, 47, 0, 0, 8'h00);
        pix("bounceL_31", 31, 48, 0, 1, 8'hE0);
        pix("bounceL_32", 32, 48, 0, 0, 8'h00);
        pix("bounceL_48", 48, 48, 0, 1, 8'hE0);
        edges(1);
        pix("right_in", 1, 48, 0, 1, 8'hE0);
        pix("right_out", 0, 48, 0, 0, 8'h00);
        // three-cycle hit; later cycles land while dead and must be ignored
        pause = 1'b0; hit_w_enemy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        hit_w_enemy = 1'b0; pause = 1'b1;
        cmp("hit/active", 32'(is_active), 32'd0);
        pix("dead_a", 1, 48, 0, 0, 8'h00);
        pix("dead_b", 64, 32, 0, 0, 8'h00);
        g = 0;
        pause = 1'b0;
        while (m.active == 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
            cmp("resp/active", 32'(is_active), 32'(m.active != 0));
        end
        pause = 1'b1;
        cmp("resp/edges", 32'(g), 32'd62);
        pix("resp_in", 64, 32, 0, 1, 8'hE0);
        pix("resp_out", 63, 32, 0, 0, 8'h00);
        wave_speed = 24'd3;
        edges(6);
        sx = m.wx;
        repeat (1000) @(posedge clk);
        #1;
        pix("pause_in", sx, 32, 0, 1, 8'hE0);
        pix("pause_out", sx - 1, 32, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            edges(1);
            pixm("after_pause_a", m.wx, m.wy, 0);
            pixm("after_pause_b", m.wx - 1, m.wy, 0);
        end
        game_over_on = 1'b1;
        pix("gover", m.wx, m.wy, 0, 0, 8'h00);
        cmp("gover/active", 32'(is_active), 32'd1);
        edges(5);
        game_over_on = 1'b0;
        pixm("gover_rel", m.wx, m.wy, 0);
        edges(10);
        game_start_on = 1'b1;
        edges(1);
        pix("gstart_in", 64, 32, 0, 1, 8'hE0);
        pix("gstart_out", 63, 32, 0, 0, 8'h00);
        game_start_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edges(2);
            pixm("gstart_run_a", m.wx, m.wy, 0);
            pixm("gstart_run_b", m.wx - 1, m.wy, 0);
        end
        // let the wave descend to the floor at one step per clock
        wave_speed = 24'd0;
        g = 0;
        pause = 1'b0;
        while (m.wy + 24 < 480 && g < 60000) begin
            @(posedge clk);
            #1;
            g++;
        end
        pause = 1'b1;
        cmp("bottom/reached", 32'(g < 60000), 32'd1);
        pix("bottom_in", m.wx, 456, 0, 1, 8'hE0);
        pix("bottom_above", m.wx, 455, 0, 0, 8'h00);
        edges(1);
        pix("wrap_in", 64, 32, 0, 1, 8'hE0);
        pix("wrap_out", 63, 32, 0, 0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            pause         = $urandom_range(0, 7) == 0;
            game_over_on  = $urandom_range(0, 15) == 0;
            game_start_on = $urandom_range(0, 31) == 0;
            hit_w_enemy   = $urandom_range(0, 15) == 0;
            wave_speed    = 24'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                int px, py;
                if ($urandom_range(0, 4) == 0) begin
                    px = $urandom_range(0, 1023);
                    py = $urandom_range(0, 1023);
                end else begin
                    px = m.wx + $urandom_range(0, 239) - 8;
                    py = m.wy + $urandom_range(0, 31) - 4;
                    if (px < 0) px = 0;
                    if (py < 0) py = 0;
                end
                pixm("rand", px, py, 1'($urandom_range(0, 3) == 0));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
